// File: rtl/data_memory_streamer.sv
// data_memory_streamer: processor data memory with a combinational read port
// and a sequential valid/ready block read-out channel.
// Optional build macro STREAM_CHECKSUM_EN adds a running sum of streamed beats.
//
// state | meaning
// IDLE  | waiting for stream_start, channel not busy
// LOAD  | fetch first word of the block into stream_data
// SEND  | beat presented, waits for stream_ready, fetches next word on handshake
// DONE  | one-cycle done pulse, then back to IDLE
module data_memory_streamer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WR,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              MemtoReg,
    output logic [DATA_W-1:0] readData,
    input  logic              stream_start,
    input  logic [ADDR_W-1:0] stream_base,
    input  logic [ADDR_W:0]   stream_len,
    output logic [DATA_W-1:0] stream_data,
    output logic              stream_valid,
    input  logic              stream_ready,
    output logic              stream_busy,
    output logic              stream_done
`ifdef STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] stream_sum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] fetch_cur;
    logic [DATA_W-1:0] fetch_nxt;

    // MemtoReg only signals read intent; the read port is always live.
    logic unused_memtoreg;
    assign unused_memtoreg = MemtoReg;

    // Processor write port; memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (WR) mem[address] <= writeData;
    end

    assign readData = mem[address];

    // Stream fetches forward a same-cycle processor write so the new value streams.
    assign ptr_nxt   = ptr + ADDR_W'(1);
    assign fetch_cur = (WR && (address == ptr))     ? writeData : mem[ptr];
    assign fetch_nxt = (WR && (address == ptr_nxt)) ? writeData : mem[ptr_nxt];

    // Read-out FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            stream_data  <= '0;
            stream_valid <= 1'b0;
            stream_busy  <= 1'b0;
            stream_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stream_start) begin
                        stream_busy <= 1'b1;
                        if (stream_len == '0) begin
                            stream_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            ptr   <= stream_base;
                            cnt   <= stream_len;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    stream_data  <= fetch_cur;
                    stream_valid <= 1'b1;
                    state        <= SEND;
                end
                SEND: begin
                    if (stream_ready) begin
                        if (cnt > (ADDR_W+1)'(1)) begin
                            ptr         <= ptr_nxt;
                            cnt         <= cnt - (ADDR_W+1)'(1);
                            stream_data <= fetch_nxt;
                        end else begin
                            stream_valid <= 1'b0;
                            stream_done  <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    stream_done <= 1'b0;
                    stream_busy <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_CHECKSUM_EN
    // Running sum of accepted beats, cleared when a new transfer is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stream_sum <= '0;
        end else if (state == IDLE && stream_start) begin
            stream_sum <= '0;
        end else if (state == SEND && stream_ready) begin
            stream_sum <= stream_sum + stream_data;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_streamer.sv
// Directed bench for data_memory_streamer: read port, streaming latency,
// back-pressure, wrap-around, zero length, forwarding and mid-transfer reset.
module tb_data_memory_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        WR;
    logic [7:0]  address;
    logic [31:0] writeData;
    logic        MemtoReg;
    logic [31:0] readData;
    logic        stream_start;
    logic [7:0]  stream_base;
    logic [8:0]  stream_len;
    logic [31:0] stream_data;
    logic        stream_valid;
    logic        stream_ready;
    logic        stream_busy;
    logic        stream_done;
`ifdef STREAM_CHECKSUM_EN
    logic [31:0] stream_sum;
`endif

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    data_memory_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .WR           (WR),
        .address      (address),
        .writeData    (writeData),
        .MemtoReg     (MemtoReg),
        .readData     (readData),
        .stream_start (stream_start),
        .stream_base  (stream_base),
        .stream_len   (stream_len),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .stream_busy  (stream_busy),
        .stream_done  (stream_done)
`ifdef STREAM_CHECKSUM_EN
        ,
        .stream_sum   (stream_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        WR = 1'b1; address = a; writeData = d;
        tick();
        WR = 1'b0;
    endtask

    // Runs one transfer; cyc counts edges since the edge that sampled stream_start.
    task automatic do_stream(input string tag, input logic [7:0] base, input bit toggle);
        int          n = exp_q.size();
        int          cyc = 0;
        int          beats = 0;
        int          first_valid = -1;
        int          done_cyc = -1;
        int          exp_done;
        bit          stall = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] esum = '0;
        foreach (exp_q[i]) esum += exp_q[i];
        exp_done = (n == 0) ? 1 : (toggle ? 2 + 2 * n - 1 : 2 + n);
        stream_start = 1'b1; stream_base = base; stream_len = 9'(n);
        tick();
        stream_start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            stream_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stream_done) begin
                done_cyc = cyc;
                chk({tag, "_busy_in_done"}, 32'(stream_busy), 32'd1);
                chk({tag, "_valid_in_done"}, 32'(stream_valid), 32'd0);
`ifdef STREAM_CHECKSUM_EN
                chk({tag, "_sum"}, stream_sum, esum);
`endif
                break;
            end
            chk({tag, "_busy"}, 32'(stream_busy), 32'd1);
            if (stream_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stall) chk({tag, "_hold"}, stream_data, held);
                if (stream_ready) begin
                    if (beats < n) chk($sformatf("%s_beat%0d", tag, beats), stream_data, exp_q[beats]);
                    beats++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held  = stream_data;
                end
            end
            tick();
            cyc++;
        end
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "_beats"}, 32'(beats), 32'(n));
        chk({tag, "_first_valid"}, 32'(first_valid), (n == 0) ? 32'hFFFF_FFFF : 32'd2);
        tick();
        chk({tag, "_done_clr"}, 32'(stream_done), 32'd0);
        chk({tag, "_busy_clr"}, 32'(stream_busy), 32'd0);
        stream_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; WR = 1'b0; address = '0; writeData = '0; MemtoReg = 1'b0;
        stream_start = 1'b0; stream_base = '0; stream_len = '0; stream_ready = 1'b0;
        tick();
        chk("rst_valid", 32'(stream_valid), 32'd0);
        chk("rst_busy", 32'(stream_busy), 32'd0);
        chk("rst_done", 32'(stream_done), 32'd0);
        chk("rst_data", stream_data, 32'd0);
`ifdef STREAM_CHECKSUM_EN
        chk("rst_sum", stream_sum, 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();

        // combinational processor read
        wr(8'd1, 32'd2);
        wr(8'd2, 32'd3);
        MemtoReg = 1'b1;
        address = 8'd1; #1;
        chk("rd_addr1", readData, 32'd2);
        address = 8'd2; #1;
        chk("rd_addr2", readData, 32'd3);
        MemtoReg = 1'b0;

        // full-throughput and back-pressured block
        for (int i = 0; i < 4; i++) wr(8'(10 + i), 32'hA0 + 32'(i));
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_stream("full", 8'd10, 1'b0);
        do_stream("toggle", 8'd10, 1'b1);

        // wrap-around past the top of the array
        wr(8'hFE, 32'd1);
        wr(8'hFF, 32'd2);
        wr(8'h00, 32'd3);
        exp_q = '{32'd1, 32'd2, 32'd3};
        do_stream("wrap", 8'hFE, 1'b0);

        // zero-length request
        exp_q = {};
        do_stream("len0", 8'd10, 1'b0);

        // write to held address vs write to the address being fetched, then reset
        wr(8'h20, 32'h11);
        wr(8'h21, 32'h22);
        wr(8'h22, 32'h33);
        stream_start = 1'b1; stream_base = 8'h20; stream_len = 9'd3;
        tick();
        stream_start = 1'b0; stream_ready = 1'b0;
        tick();
        chk("fw_valid", 32'(stream_valid), 32'd1);
        chk("fw_first", stream_data, 32'h11);
        WR = 1'b1; address = 8'h20; writeData = 32'hDEAD;
        tick();
        chk("fw_held_write", stream_data, 32'h11);
        address = 8'h21; writeData = 32'hBEEF; stream_ready = 1'b1;
        tick();
        WR = 1'b0;
        chk("fw_forward", stream_data, 32'hBEEF);
        tick();
        chk("fw_third", stream_data, 32'h33);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(stream_valid), 32'd0);
        chk("mid_rst_busy", 32'(stream_busy), 32'd0);
        chk("mid_rst_done", 32'(stream_done), 32'd0);
        stream_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        exp_q = '{32'hDEAD, 32'hBEEF, 32'h33};
        do_stream("after_rst", 8'h20, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
